// File: rtl/protobuf_field_tokenizer.sv
// Protobuf wire-format tokenizer: splits a serialized byte stream into KEY/VARINT/LEN/PAYLOAD tokens.
// One registered output stage, latency 1, one byte per clock; input stalls only while a token is held.
module protobuf_field_tokenizer #(
  parameter int FIELD_NUM_W      = 5,
  parameter int VALUE_W          = 64,
  parameter int MAX_VARINT_BYTES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [FIELD_NUM_W-1:0] out_field_num,
  output logic [2:0]             out_wire_type,
  output logic [VALUE_W-1:0]     out_value,
  output logic                   out_last,
  output logic                   err_valid,
  output logic [1:0]             err_code
);
  localparam int IDX_W = $clog2(MAX_VARINT_BYTES + 1);
  localparam int SH_W  = VALUE_W + 7 * (MAX_VARINT_BYTES + 1);

  localparam logic [1:0] K_KEY = 2'd0, K_VARINT = 2'd1, K_LEN = 2'd2, K_PAY = 2'd3;
  localparam logic [1:0] E_FIELD_RANGE = 2'd0, E_VARINT_OVF = 2'd1,
                         E_BAD_WIRETYPE = 2'd2, E_TRUNCATED = 2'd3;

  typedef enum logic [2:0] {S_KEY, S_VARINT, S_LEN, S_PAY, S_FIX, S_DROP} state_t;

  state_t                 state, state_n;
  logic [VALUE_W-1:0]     acc, acc_n, cnt, cnt_n, acc_upd, emit_val;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [FIELD_NUM_W-1:0] fnum, fnum_n;
  logic [2:0]             wtype, wtype_n, key_wt;
  logic [SH_W-1:0]        shifted;
  logic                   fire, term, ovf, emit, err, key_range_bad;
  logic [1:0]             emit_kind, err_c;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;
  assign term     = !in_data[7];

  // Shift into a wide lane so bits that would fall off the top of acc are still visible.
  assign shifted       = SH_W'(in_data[6:0]) << (7 * idx);
  assign acc_upd       = acc | shifted[VALUE_W-1:0];
  assign ovf           = (idx == IDX_W'(MAX_VARINT_BYTES)) || (|shifted[SH_W-1:VALUE_W]);
  assign key_wt        = acc_upd[2:0];
  assign key_range_bad = (acc_upd[VALUE_W-1:3] == '0) || (|acc_upd[VALUE_W-1:3+FIELD_NUM_W]);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    idx_n     = idx;
    cnt_n     = cnt;
    fnum_n    = fnum;
    wtype_n   = wtype;
    emit      = 1'b0;
    emit_kind = K_KEY;
    emit_val  = '0;
    err       = 1'b0;
    err_c     = E_FIELD_RANGE;
    if (fire) begin
      acc_n = '0;
      idx_n = '0;
      case (state)
        S_KEY, S_VARINT, S_LEN: begin
          if (ovf) begin
            err     = 1'b1;
            err_c   = E_VARINT_OVF;
            state_n = in_last ? S_KEY : S_DROP;
          end else if (!term) begin
            if (in_last) begin
              err     = 1'b1;
              err_c   = E_TRUNCATED;
              state_n = S_KEY;
            end else begin
              acc_n = acc_upd;
              idx_n = idx + 1'b1;
            end
          end else if (state == S_KEY) begin
            if (key_wt == 3'd3 || key_wt == 3'd4 || key_wt == 3'd6 || key_wt == 3'd7) begin
              err     = 1'b1;
              err_c   = E_BAD_WIRETYPE;
              state_n = in_last ? S_KEY : S_DROP;
            end else if (key_range_bad) begin
              err     = 1'b1;
              err_c   = E_FIELD_RANGE;
              state_n = in_last ? S_KEY : S_DROP;
            end else if (in_last) begin
              err     = 1'b1;
              err_c   = E_TRUNCATED;
              state_n = S_KEY;
            end else begin
              emit      = 1'b1;
              emit_kind = K_KEY;
              emit_val  = acc_upd;
              fnum_n    = acc_upd[3 +: FIELD_NUM_W];
              wtype_n   = key_wt;
              case (key_wt)
                3'd0:    state_n = S_VARINT;
                3'd2:    state_n = S_LEN;
                3'd1: begin
                  cnt_n   = VALUE_W'(8);
                  state_n = S_FIX;
                end
                default: begin
                  cnt_n   = VALUE_W'(4);
                  state_n = S_FIX;
                end
              endcase
            end
          end else if (state == S_VARINT) begin
            emit      = 1'b1;
            emit_kind = K_VARINT;
            emit_val  = acc_upd;
            state_n   = S_KEY;
          end else begin
            // A zero-length LEN completes its field, so it may legally carry in_last.
            if (acc_upd == '0) begin
              emit      = 1'b1;
              emit_kind = K_LEN;
              state_n   = S_KEY;
            end else if (in_last) begin
              err     = 1'b1;
              err_c   = E_TRUNCATED;
              state_n = S_KEY;
            end else begin
              emit      = 1'b1;
              emit_kind = K_LEN;
              emit_val  = acc_upd;
              cnt_n     = acc_upd;
              state_n   = S_PAY;
            end
          end
        end
        S_PAY, S_FIX: begin
          if (cnt == VALUE_W'(1)) begin
            emit      = 1'b1;
            emit_kind = K_PAY;
            emit_val  = VALUE_W'(in_data);
            cnt_n     = '0;
            state_n   = S_KEY;
          end else if (in_last) begin
            err     = 1'b1;
            err_c   = E_TRUNCATED;
            cnt_n   = '0;
            state_n = S_KEY;
          end else begin
            emit      = 1'b1;
            emit_kind = K_PAY;
            emit_val  = VALUE_W'(in_data);
            cnt_n     = cnt - 1'b1;
          end
        end
        S_DROP: begin
          if (in_last) state_n = S_KEY;
        end
        default: state_n = S_KEY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_KEY;
      acc           <= '0;
      idx           <= '0;
      cnt           <= '0;
      fnum          <= '0;
      wtype         <= '0;
      out_valid     <= 1'b0;
      out_kind      <= '0;
      out_field_num <= '0;
      out_wire_type <= '0;
      out_value     <= '0;
      out_last      <= 1'b0;
      err_valid     <= 1'b0;
      err_code      <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      fnum  <= fnum_n;
      wtype <= wtype_n;
      if (fire && emit) begin
        out_valid     <= 1'b1;
        out_kind      <= emit_kind;
        out_field_num <= fnum_n;
        out_wire_type <= wtype_n;
        out_value     <= emit_val;
        out_last      <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      err_valid <= fire && err;
      err_code  <= (fire && err) ? err_c : 2'd0;
    end
  end
endmodule

// File: tb/tb_protobuf_field_tokenizer.sv
// Bench for protobuf_field_tokenizer: message-level parse model feeding a token/error scoreboard,
// directed wire-format cases with literal expectations, then randomized messages under random backpressure.
module tb_protobuf_field_tokenizer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_ready = 1'b1, out_last, err_valid;
  logic [1:0]  out_kind, err_code;
  logic [4:0]  out_field_num;
  logic [2:0]  out_wire_type;
  logic [63:0] out_value;

  protobuf_field_tokenizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_field_num(out_field_num), .out_wire_type(out_wire_type), .out_value(out_value),
    .out_last(out_last), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  fn;
    logic [2:0]  wt;
    logic [63:0] val;
    logic        last;
  } tok_t;

  tok_t       exp_tok[$];
  int         exp_err[$];
  logic [7:0] msg[$];
  int         tests = 0, fails = 0;
  bit         chk_en = 1'b0, gaps = 1'b0;
  int         rmode = 0, low_cnt = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_tok(logic [1:0] k, logic [4:0] fn, logic [2:0] wt, logic [63:0] v, logic l);
    tok_t t;
    t = {k, fn, wt, v, l};
    exp_tok.push_back(t);
  endfunction

  // Reads one varint starting at msg[p]. Returns 0 done, 1 overflow, 2 ran into the last byte.
  function automatic int read_varint(input int n, inout int p, output logic [63:0] v);
    int i;
    bit ovf, l;
    logic [7:0] b;
    v = '0;
    i = 0;
    while (1) begin
      b = msg[p];
      l = (p == n - 1);
      ovf = (i >= 10);
      for (int k = 0; k < 7; k++)
        if (b[k]) begin
          if (7 * i + k >= 64) ovf = 1'b1;
          else v[7 * i + k] = 1'b1;
        end
      p++;
      if (ovf) return 1;
      if (!b[7]) return 0;
      if (l) return 2;
      i++;
    end
    return 0;
  endfunction

  // Parses msg as one whole message; the first error ends the message (rest is dropped).
  function automatic void model_msg();
    int n, p, st;
    logic [63:0] key, v, rem;
    logic [4:0] fn;
    logic [2:0] wt;
    logic l;
    n = msg.size();
    p = 0;
    while (p < n) begin
      st = read_varint(n, p, key);
      if (st == 1) begin exp_err.push_back(1); return; end
      if (st == 2) begin exp_err.push_back(3); return; end
      wt = key[2:0];
      if (wt == 3 || wt == 4 || wt == 6 || wt == 7) begin exp_err.push_back(2); return; end
      if ((key >> 3) == 0 || (key >> 3) > 31) begin exp_err.push_back(0); return; end
      if (p == n) begin exp_err.push_back(3); return; end
      fn = key[7:3];
      push_tok(2'd0, fn, wt, key, 1'b0);
      if (wt == 0) begin
        st = read_varint(n, p, v);
        if (st != 0) begin exp_err.push_back(st == 1 ? 1 : 3); return; end
        push_tok(2'd1, fn, wt, v, p == n);
        continue;
      end
      if (wt == 2) begin
        st = read_varint(n, p, v);
        if (st != 0) begin exp_err.push_back(st == 1 ? 1 : 3); return; end
        if (v == 0) begin push_tok(2'd2, fn, wt, 64'd0, p == n); continue; end
        if (p == n) begin exp_err.push_back(3); return; end
        push_tok(2'd2, fn, wt, v, 1'b0);
        rem = v;
      end else begin
        rem = (wt == 1) ? 64'd8 : 64'd4;
      end
      while (rem != 0) begin
        l = (p == n - 1);
        if (rem == 1) push_tok(2'd3, fn, wt, {56'd0, msg[p]}, l);
        else if (l) begin exp_err.push_back(3); return; end
        else push_tok(2'd3, fn, wt, {56'd0, msg[p]}, 1'b0);
        p++;
        rem--;
      end
    end
  endfunction

  function automatic void push_varint(logic [63:0] v);
    logic [7:0] b;
    do begin
      b = {1'b0, v[6:0]};
      v = v >> 7;
      if (v != 0) b[7] = 1'b1;
      msg.push_back(b);
    end while (v != 0);
  endfunction

  task automatic gen_msg();
    int nf, r, fn, wt, len;
    int bad[4], good[4];
    bad  = '{3, 4, 6, 7};
    good = '{0, 1, 2, 5};
    msg.delete();
    nf = $urandom_range(1, 4);
    for (int f = 0; f < nf; f++) begin
      r  = $urandom_range(0, 99);
      fn = $urandom_range(1, 31);
      if (r < 4) fn = 0;
      else if (r < 8) fn = $urandom_range(32, 200);
      wt = ($urandom_range(0, 99) < 6) ? bad[$urandom_range(0, 3)] : good[$urandom_range(0, 3)];
      push_varint(64'(fn) * 8 + 64'(wt));
      case (wt)
        0: begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            repeat (11) msg.push_back(8'hFF);
            msg.push_back(8'h01);
          end else if (r == 1) push_varint('1);
          else push_varint({$urandom, $urandom} >> $urandom_range(0, 63));
        end
        2: begin
          len = $urandom_range(0, 5);
          push_varint(64'(len));
          repeat (len) msg.push_back(8'($urandom));
        end
        1: repeat (8) msg.push_back(8'($urandom));
        5: repeat (4) msg.push_back(8'($urandom));
        default: repeat (2) msg.push_back(8'($urandom));
      endcase
    end
    if ($urandom_range(0, 9) < 2) begin
      len = $urandom_range(1, msg.size());
      while (msg.size() > len) void'(msg.pop_back());
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int  guard;
    bit  taken;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    taken    = 1'b0;
    guard    = 0;
    while (!taken) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
      guard++;
      if (guard > 1000) begin
        fails++;
        $display("FAIL in_ready_timeout: byte 0x%0h not accepted in 1000 cycles", b);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_tok.size() != 0 || exp_err.size() != 0 || out_valid) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    tests++;
    if (g >= 400) begin
      fails++;
      $display("FAIL drain: %0d tokens and %0d errors still expected", exp_tok.size(), exp_err.size());
      exp_tok.delete();
      exp_err.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic pin(input int i, input logic [1:0] k, input logic [4:0] fn, input logic [2:0] wt,
                     input logic [63:0] v, input logic l);
    tok_t w;
    w = {k, fn, wt, v, l};
    if (i >= exp_tok.size()) begin
      tests++;
      fails++;
      $display("FAIL pin_tok%0d: model has only %0d tokens, expected 0x%0h", i, exp_tok.size(), w);
    end else chk($sformatf("pin_tok%0d", i), exp_tok[i], w);
  endtask

  task automatic run_directed(input int ntok, input int nerr, input int err0);
    model_msg();
    chk("pin_ntok", exp_tok.size(), ntok);
    chk("pin_nerr", exp_err.size(), nerr);
    if (nerr > 0 && exp_err.size() > 0) chk("pin_err", exp_err[0], err0);
  endtask

  // Backpressure: 0 always ready, 1 alternating, 2 random; low_cnt forces a stall window.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (low_cnt > 0) begin
        out_ready = 1'b0;
        low_cnt--;
      end else if (rmode == 1) out_ready = ~out_ready;
      else if (rmode == 2) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
    end
  end

  initial begin
    tok_t got, h, e;
    bit   held;
    int   ec;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        held = 1'b0;
        continue;
      end
      got = {out_kind, out_field_num, out_wire_type, out_value, out_last};
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) chk("hold_stable", {out_valid, got}, {1'b1, h});
      if (out_valid && out_ready) begin
        if (exp_tok.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_token: got 0x%0h with none expected", got);
        end else begin
          e = exp_tok.pop_front();
          chk("token", got, e);
        end
      end
      held = out_valid && !out_ready;
      h    = got;
      if (err_valid) begin
        if (exp_err.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_error: got code %0d with none expected", err_code);
        end else begin
          ec = exp_err.pop_front();
          chk("err_code", err_code, ec);
        end
      end
    end
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    msg = {8'h08, 8'h96, 8'h01};
    run_directed(2, 0, 0);
    pin(0, 2'd0, 5'd1, 3'd0, 64'h08, 1'b0);
    pin(1, 2'd1, 5'd1, 3'd0, 64'd150, 1'b1);
    send_msg(); drain();

    msg = {8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
    run_directed(5, 0, 0);
    pin(0, 2'd0, 5'd2, 3'd2, 64'h12, 1'b0);
    pin(1, 2'd2, 5'd2, 3'd2, 64'd3, 1'b0);
    pin(2, 2'd3, 5'd2, 3'd2, 64'h61, 1'b0);
    pin(4, 2'd3, 5'd2, 3'd2, 64'h63, 1'b1);
    send_msg(); drain();

    rmode = 1;
    model_msg(); send_msg(); drain();
    low_cnt = 5;
    model_msg(); send_msg(); drain();
    rmode = 0;

    msg = {8'h08};
    repeat (11) msg.push_back(8'hFF);
    msg.push_back(8'h01);
    run_directed(1, 1, 1);
    send_msg(); drain();
    msg = {8'h08, 8'h96, 8'h01};
    model_msg(); send_msg(); drain();

    msg = {8'h0B, 8'h55, 8'h66};
    run_directed(0, 1, 2);
    send_msg(); drain();
    msg = {8'h1A, 8'h05, 8'h61};
    run_directed(2, 1, 3);
    pin(1, 2'd2, 5'd3, 3'd2, 64'd5, 1'b0);
    send_msg(); drain();

    msg = {8'h0A, 8'h00};
    run_directed(2, 0, 0);
    pin(1, 2'd2, 5'd1, 3'd2, 64'd0, 1'b1);
    send_msg(); drain();

    // Abort a message mid-payload; the pending token must vanish with reset.
    chk_en = 1'b0;
    send_byte(8'h12, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h61, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_value", out_value, 0);
    chk("midrst_out_kind", out_kind, 0);
    chk("midrst_err_valid", err_valid, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    msg = {8'h08, 8'h2A};
    run_directed(2, 0, 0);
    pin(0, 2'd0, 5'd1, 3'd0, 64'h08, 1'b0);
    pin(1, 2'd1, 5'd1, 3'd0, 64'd42, 1'b1);
    send_msg(); drain();

    rmode = 2;
    gaps  = 1'b1;
    for (int m = 0; m < 60; m++) begin
      gen_msg();
      model_msg();
      send_msg();
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
